// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I-subset control unit: sequences one shared ALU and one unified
// memory port across several cycles per instruction, with Mem_Ready stretching.
module multicycle_control_fsm #(
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_bit_5,
   input  logic       Zero,
   input  logic       Mem_Ready,
   output logic       PC_Write,
   output logic       Adr_Src,
   output logic       Mem_Write,
   output logic       IR_Write,
   output logic       Reg_Write,
   output logic [1:0] Result_Src,
   output logic [1:0] ALU_Src_A,
   output logic [1:0] ALU_Src_B,
   output logic [1:0] Imm_Src,
   output logic [2:0] ALU_Control,
   output logic       Halted,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_HALT     = 4'd15
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   state_t state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         case (state_q)
            S_FETCH:    if (Mem_Ready) state_q <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: state_q <= S_MEMADR;
                  OP_R:         state_q <= S_EXECUTER;
                  OP_I:         state_q <= S_EXECUTEI;
                  OP_BEQ:       state_q <= S_BEQ;
                  OP_JAL:       state_q <= S_JAL;
                  default:      state_q <= TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
               endcase
            end
            S_MEMADR:   state_q <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (Mem_Ready) state_q <= S_MEMWB;
            S_MEMWB:    state_q <= S_FETCH;
            S_MEMWRITE: if (Mem_Ready) state_q <= S_FETCH;
            S_EXECUTER: state_q <= S_ALUWB;
            S_EXECUTEI: state_q <= S_ALUWB;
            S_ALUWB:    state_q <= S_FETCH;
            S_BEQ:      state_q <= S_FETCH;
            S_JAL:      state_q <= S_ALUWB;
            S_HALT:     state_q <= S_HALT;
            default:    state_q <= S_FETCH;
         endcase
      end
   end

   // While rst is held the outputs already show FETCH, with every enable masked.
   state_t     eff_state;
   logic       pc_update, branch, ir_wr, mem_wr, reg_wr;
   logic [1:0] alu_op;

   always_comb begin
      eff_state  = rst ? S_FETCH : state_q;
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_wr      = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      alu_op     = 2'b00;
      Adr_Src    = 1'b0;
      Result_Src = 2'b00;
      ALU_Src_A  = 2'b00;
      ALU_Src_B  = 2'b00;
      case (eff_state)
         S_FETCH: begin
            ALU_Src_B  = 2'b10;
            Result_Src = 2'b10;
            ir_wr      = Mem_Ready;
            pc_update  = Mem_Ready;
         end
         S_DECODE: begin
            ALU_Src_A = 2'b01;
            ALU_Src_B = 2'b01;
         end
         S_MEMADR: begin
            ALU_Src_A = 2'b10;
            ALU_Src_B = 2'b01;
         end
         S_MEMREAD:  Adr_Src = 1'b1;
         S_MEMWB: begin
            Result_Src = 2'b01;
            reg_wr     = 1'b1;
         end
         S_MEMWRITE: begin
            Adr_Src = 1'b1;
            mem_wr  = 1'b1;
         end
         S_EXECUTER: begin
            ALU_Src_A = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXECUTEI: begin
            ALU_Src_A = 2'b10;
            ALU_Src_B = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALUWB:    reg_wr = 1'b1;
         S_BEQ: begin
            ALU_Src_A = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
         S_JAL: begin
            ALU_Src_A = 2'b01;
            ALU_Src_B = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   assign PC_Write  = ~rst & (pc_update | (branch & Zero));
   assign IR_Write  = ~rst & ir_wr;
   assign Mem_Write = ~rst & mem_wr;
   assign Reg_Write = ~rst & reg_wr;
   assign Halted    = (eff_state == S_HALT);
   assign State     = eff_state;

   always_comb begin
      case (op)
         OP_SW:   Imm_Src = 2'b01;
         OP_BEQ:  Imm_Src = 2'b10;
         OP_JAL:  Imm_Src = 2'b11;
         default: Imm_Src = 2'b00;
      endcase
   end

   // Subtract only for R-type (op[5]=1) with bit 30 set; addi never subtracts.
   always_comb begin
      ALU_Control = 3'b000;
      case (alu_op)
         2'b01: ALU_Control = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALU_Control = (op[5] & funct7_bit_5) ? 3'b001 : 3'b000;
               3'b010:  ALU_Control = 3'b101;
               3'b110:  ALU_Control = 3'b011;
               3'b111:  ALU_Control = 3'b010;
               default: ALU_Control = 3'b000;
            endcase
         end
         default: ALU_Control = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a cycle-trace vector table, hand-written HALT and
// mid-instruction reset sequences, then random instructions against a path-based model.
module tb_multicycle_control_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, funct7_bit_5, Zero, Mem_Ready;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       PC_Write, Adr_Src, Mem_Write, IR_Write, Reg_Write, Halted;
   logic [1:0] Result_Src, ALU_Src_A, ALU_Src_B, Imm_Src;
   logic [2:0] ALU_Control;
   logic [3:0] State;

   multicycle_control_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_bit_5(funct7_bit_5),
      .Zero(Zero), .Mem_Ready(Mem_Ready), .PC_Write(PC_Write), .Adr_Src(Adr_Src),
      .Mem_Write(Mem_Write), .IR_Write(IR_Write), .Reg_Write(Reg_Write),
      .Result_Src(Result_Src), .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B),
      .Imm_Src(Imm_Src), .ALU_Control(ALU_Control), .Halted(Halted), .State(State)
   );

   localparam int OP_LW  = 7'b0000011;
   localparam int OP_SW  = 7'b0100011;
   localparam int OP_R   = 7'b0110011;
   localparam int OP_I   = 7'b0010011;
   localparam int OP_BEQ = 7'b1100011;
   localparam int OP_JAL = 7'b1101111;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, z, mr;
      logic [3:0] st;
      logic       pcw, irw, mw, rw;
      logic [2:0] alu;
      logic       hlt;
   } vec_t;

   vec_t tbl[$];

   // {Adr_Src, Result_Src, ALU_Src_A, ALU_Src_B} for each state code.
   function automatic logic [6:0] ctl_of(input logic [3:0] st);
      case (st)
         4'd0:    return {1'b0, 2'b10, 2'b00, 2'b10};
         4'd1:    return {1'b0, 2'b00, 2'b01, 2'b01};
         4'd2:    return {1'b0, 2'b00, 2'b10, 2'b01};
         4'd3:    return {1'b1, 2'b00, 2'b00, 2'b00};
         4'd4:    return {1'b0, 2'b01, 2'b00, 2'b00};
         4'd5:    return {1'b1, 2'b00, 2'b00, 2'b00};
         4'd6:    return {1'b0, 2'b00, 2'b10, 2'b00};
         4'd7:    return {1'b0, 2'b00, 2'b10, 2'b01};
         4'd9:    return {1'b0, 2'b00, 2'b10, 2'b00};
         4'd10:   return {1'b0, 2'b00, 2'b01, 2'b10};
         default: return 7'd0;
      endcase
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      if (o == 7'(OP_SW))  return 2'b01;
      if (o == 7'(OP_BEQ)) return 2'b10;
      if (o == 7'(OP_JAL)) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [20:0] expect_vec(input logic [3:0] st, input logic pcw, irw, mw, rw,
                                              input logic [6:0] o, input logic [2:0] alu,
                                              input logic hlt);
      return {st, pcw, irw, mw, rw, ctl_of(st), imm_of(o), alu, hlt};
   endfunction

   task automatic v(input int r, o, f3, f7, z, mr, st, pcw, irw, mw, rw, alu, hlt);
      vec_t e;
      e.rst = 1'(r);   e.op = 7'(o);    e.f3 = 3'(f3);   e.f7 = 1'(f7);
      e.z = 1'(z);     e.mr = 1'(mr);   e.st = 4'(st);   e.pcw = 1'(pcw);
      e.irw = 1'(irw); e.mw = 1'(mw);   e.rw = 1'(rw);   e.alu = 3'(alu);
      e.hlt = 1'(hlt);
      tbl.push_back(e);
   endtask

   task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, z, mr);
      @(negedge clk);
      rst = r; op = o; funct3 = f3; funct7_bit_5 = f7; Zero = z; Mem_Ready = mr;
      #1;
   endtask

   task automatic check(input string name, input logic [20:0] exp);
      logic [20:0] act;
      act = {State, PC_Write, IR_Write, Mem_Write, Reg_Write, Adr_Src, Result_Src,
             ALU_Src_A, ALU_Src_B, Imm_Src, ALU_Control, Halted};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %06h want %06h (state %0d vs %0d)", name, act, exp,
                  act[20:17], exp[20:17]);
      end
   endtask

   // Reference model state for random instructions.
   int         path[$];
   int         cls, cur, cyc;
   logic [6:0] r_op;
   logic [2:0] r_f3, e_alu;
   logic       r_f7, r_z, r_mr, e_pcw;

   initial begin
      rst = 1'b1; op = 7'(OP_R); funct3 = 3'd0; funct7_bit_5 = 1'b0; Zero = 1'b0;
      Mem_Ready = 1'b1;

      //  rst op      f3 f7 z mr  st pcw irw mw rw alu hlt
      v(1, OP_R,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
      v(1, OP_R,   0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0);
      v(0, OP_LW,  2, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_LW,  2, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_LW,  2, 0, 0, 1,  2, 0, 0, 0, 0, 0, 0);
      v(0, OP_LW,  2, 0, 0, 1,  3, 0, 0, 0, 0, 0, 0);
      v(0, OP_LW,  2, 0, 0, 1,  4, 0, 0, 0, 1, 0, 0);
      v(0, OP_SW,  2, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_SW,  2, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_SW,  2, 0, 0, 1,  2, 0, 0, 0, 0, 0, 0);
      v(0, OP_SW,  2, 0, 0, 0,  5, 0, 0, 1, 0, 0, 0);
      v(0, OP_SW,  2, 0, 1, 0,  5, 0, 0, 1, 0, 0, 0);
      v(0, OP_SW,  2, 0, 0, 1,  5, 0, 0, 1, 0, 0, 0);
      v(0, OP_R,   0, 1, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_R,   0, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_R,   0, 1, 1, 1,  6, 0, 0, 0, 0, 1, 0);
      v(0, OP_R,   0, 1, 0, 1,  8, 0, 0, 0, 1, 0, 0);
      v(0, OP_I,   0, 1, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_I,   0, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_I,   0, 1, 0, 1,  7, 0, 0, 0, 0, 0, 0);
      v(0, OP_I,   0, 1, 0, 1,  8, 0, 0, 0, 1, 0, 0);
      v(0, OP_R,   7, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_R,   7, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_R,   7, 0, 0, 1,  6, 0, 0, 0, 0, 2, 0);
      v(0, OP_R,   7, 0, 0, 1,  8, 0, 0, 0, 1, 0, 0);
      v(0, OP_R,   2, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_R,   2, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_R,   2, 0, 0, 1,  6, 0, 0, 0, 0, 5, 0);
      v(0, OP_R,   2, 0, 0, 1,  8, 0, 0, 0, 1, 0, 0);
      v(0, OP_I,   6, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_I,   6, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_I,   6, 0, 0, 1,  7, 0, 0, 0, 0, 3, 0);
      v(0, OP_I,   6, 0, 0, 1,  8, 0, 0, 0, 1, 0, 0);
      v(0, OP_BEQ, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_BEQ, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_BEQ, 0, 0, 1, 1,  9, 1, 0, 0, 0, 1, 0);
      v(0, OP_BEQ, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_BEQ, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_BEQ, 0, 0, 0, 1,  9, 0, 0, 0, 0, 1, 0);
      v(0, OP_JAL, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
      v(0, OP_JAL, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      v(0, OP_JAL, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      v(0, OP_JAL, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0);
      v(0, OP_JAL, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0);
      v(0, OP_JAL, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0);
      v(0, OP_JAL, 0, 0, 1, 1,  8, 0, 0, 0, 1, 0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].mr);
         check($sformatf("vec%0d", i),
               expect_vec(tbl[i].st, tbl[i].pcw, tbl[i].irw, tbl[i].mw, tbl[i].rw,
                          tbl[i].op, tbl[i].alu, tbl[i].hlt));
         $display("vec %0d: op=%b st=%0d pcw=%b rw=%b alu=%0d", i, op, State, PC_Write,
                  Reg_Write, ALU_Control);
      end

      // Illegal opcode traps into HALT, which only reset leaves.
      step(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      check("ill_fetch", expect_vec(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0));
      step(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      check("ill_decode", expect_vec(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0));
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 7'd0, 3'd0, 1'b0, 1'b1, 1'b1);
         check($sformatf("halt%0d", k),
               expect_vec(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b1));
      end
      step(1'b1, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      check("halt_rst", expect_vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0));
      step(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      check("halt_exit", expect_vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0));
      $display("seq halt: done, state=%0d", State);

      // Reset lands in MEMREAD: the load must never reach MEMWB.
      step(1'b0, 7'(OP_LW), 3'd2, 1'b0, 1'b0, 1'b1);
      check("mid_fetch", expect_vec(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'(OP_LW), 3'd0, 1'b0));
      step(1'b0, 7'(OP_LW), 3'd2, 1'b0, 1'b0, 1'b1);
      check("mid_decode", expect_vec(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'(OP_LW), 3'd0, 1'b0));
      step(1'b0, 7'(OP_LW), 3'd2, 1'b0, 1'b0, 1'b1);
      check("mid_memadr", expect_vec(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'(OP_LW), 3'd0, 1'b0));
      step(1'b0, 7'(OP_LW), 3'd2, 1'b0, 1'b0, 1'b0);
      check("mid_memread", expect_vec(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 7'(OP_LW), 3'd0, 1'b0));
      step(1'b1, 7'(OP_LW), 3'd2, 1'b0, 1'b0, 1'b1);
      check("mid_rst", expect_vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'(OP_LW), 3'd0, 1'b0));
      step(1'b0, 7'(OP_LW), 3'd2, 1'b0, 1'b0, 1'b0);
      check("mid_after", expect_vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'(OP_LW), 3'd0, 1'b0));
      $display("seq reset-in-memread: done, state=%0d", State);

      // Random instructions: each class walks a fixed list of state codes, with the
      // memory states repeating while Mem_Ready is low.
      for (int n = 0; n < 150; n++) begin
         cls  = $urandom_range(0, 5);
         r_f3 = 3'($urandom_range(0, 7));
         r_f7 = 1'($urandom_range(0, 1));
         case (cls)
            0:       begin r_op = 7'(OP_LW);  path = {0, 1, 2, 3, 4}; end
            1:       begin r_op = 7'(OP_SW);  path = {0, 1, 2, 5};    end
            2:       begin r_op = 7'(OP_R);   path = {0, 1, 6, 8};    end
            3:       begin r_op = 7'(OP_I);   path = {0, 1, 7, 8};    end
            4:       begin r_op = 7'(OP_BEQ); path = {0, 1, 9};       end
            default: begin r_op = 7'(OP_JAL); path = {0, 1, 10, 8};   end
         endcase
         cyc = 0;
         while (path.size() > 0) begin
            r_mr = ($urandom_range(0, 3) != 0);
            r_z  = 1'($urandom_range(0, 1));
            step(1'b0, r_op, r_f3, r_f7, r_z, r_mr);
            cur = path[0];
            e_alu = 3'd0;
            if (cur == 6 || cur == 7) begin
               case (r_f3)
                  3'd0:    e_alu = (cls == 2 && r_f7) ? 3'd1 : 3'd0;
                  3'd2:    e_alu = 3'd5;
                  3'd6:    e_alu = 3'd3;
                  3'd7:    e_alu = 3'd2;
                  default: e_alu = 3'd0;
               endcase
            end else if (cur == 9) begin
               e_alu = 3'd1;
            end
            e_pcw = (cur == 0 && r_mr) || (cur == 10) || (cur == 9 && r_z);
            check($sformatf("rnd%0d_c%0d", n, cyc),
                  expect_vec(4'(cur), e_pcw, (cur == 0 && r_mr), (cur == 5),
                             (cur == 4 || cur == 8), r_op, e_alu, 1'b0));
            if (!((cur == 0 || cur == 3 || cur == 5) && !r_mr)) path.pop_front();
            cyc++;
            if (cyc > 200) begin
               total++;
               bad++;
               $display("FAIL rnd%0d_bound: got %0d cycles want <= 200", n, cyc);
               path.delete();
            end
         end
         $display("rnd %0d: op=%b f3=%0d f7=%b cycles=%0d", n, r_op, r_f3, r_f7, cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
